// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one register port between NUM_REQ requesters.
// Optional per-requester grant counters: define MEM_PORT_ARBITER_GRANT_CNT_EN.
module mem_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          en_o,
  output logic                          we_o,
  output logic [ADDR_WIDTH-1:0]         address_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  input  logic [DATA_WIDTH-1:0]         data_i,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt_o
);

  localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         rd_idx;
  logic                  rd_pend;
  logic [IW-1:0]         win;
  logic                  found;
  logic                  gnt_any;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  rd_gnt;
  logic [IW-1:0]         ptr_nxt;

  // Pick first requester at/after rr_ptr, else wrap to the lowest one
  always_comb begin
    found     = 1'b0;
    win       = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[k] && (IW'(k) >= rr_ptr)) begin
        found     = 1'b1;
        win       = IW'(k);
        sel_we    = we_i[k];
        sel_addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[k]) begin
        found     = 1'b1;
        win       = IW'(k);
        sel_we    = we_i[k];
        sel_addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Grant and downstream drive; everything idles to zero in reset
  always_comb begin
    gnt_any   = found && !rst_i;
    gnt_o     = gnt_any ? (NUM_REQ'(1) << win) : '0;
    en_o      = gnt_any;
    we_o      = gnt_any && sel_we;
    address_o = gnt_any ? sel_addr : '0;
    data_o    = (gnt_any && sel_we) ? sel_wdata : '0;
    rd_gnt    = gnt_any && !sel_we;
    ptr_nxt   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    rvalid_o  = (rd_pend && !rst_i) ? (NUM_REQ'(1) << rd_idx) : '0;
    rdata_o   = data_i;
  end

  // Round-robin pointer and outstanding-read tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr  <= '0;
      rd_pend <= 1'b0;
      rd_idx  <= '0;
    end else begin
      if (gnt_any) begin
        rr_ptr <= ptr_nxt;
      end
      rd_pend <= rd_gnt;
      if (rd_gnt) begin
        rd_idx <= win;
      end
    end
  end

`ifdef MEM_PORT_ARBITER_GRANT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

  // Per-requester grant counters, wrapping naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (gnt_o[k]) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
`else
  assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (NUM_REQ=2).
// Inputs change after negedge; outputs checked 1ns later.
module tb_mem_port_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [1:0]   req_i;
  logic [1:0]   we_i;
  logic [127:0] addr_i;
  logic [127:0] wdata_i;
  logic [1:0]   gnt_o;
  logic [1:0]   rvalid_o;
  logic [63:0]  rdata_o;
  logic         en_o;
  logic         we_o;
  logic [63:0]  address_o;
  logic [63:0]  data_o;
  logic [63:0]  data_i;
  logic [63:0]  grant_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .en_o        (en_o),
    .we_o        (we_o),
    .address_o   (address_o),
    .data_o      (data_o),
    .data_i      (data_i),
    .grant_cnt_o (grant_cnt_o)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  logic [1:0]  fair_exp [4];
  logic [63:0] cnt_exp;

  initial begin
    fair_exp[0] = 2'b01;
    fair_exp[1] = 2'b10;
    fair_exp[2] = 2'b01;
    fair_exp[3] = 2'b10;
`ifdef MEM_PORT_ARBITER_GRANT_CNT_EN
    cnt_exp = {32'd2, 32'd2};
`else
    cnt_exp = '0;
`endif

    rst_i   = 1'b1;
    req_i   = '0;
    we_i    = '0;
    addr_i  = '0;
    wdata_i = '0;
    data_i  = '0;

    // reset: requests must be ignored
    cyc(); req_i = 2'b11; #1;
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_en", en_o, 1'b0);
    chk("rst_rvalid", rvalid_o, 2'b00);
    cyc(); req_i = 2'b00; #1;
    chk("rst_en2", en_o, 1'b0);

    // idle after reset
    cyc(); rst_i = 1'b0; #1;
    chk("idle_gnt", gnt_o, 2'b00);
    chk("idle_en", en_o, 1'b0);
    chk("idle_rvalid", rvalid_o, 2'b00);
    chk("idle_addr", address_o, 64'h0);
    chk("idle_cnt", grant_cnt_o, 64'h0);

    // fairness with writes
    addr_i  = {64'h18, 64'h10};
    wdata_i = {64'hB1, 64'hA0};
    we_i    = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cyc(); req_i = 2'b11; #1;
      chk($sformatf("fair_gnt%0d", i), gnt_o, fair_exp[i]);
    end
    cyc(); req_i = 2'b00; #1;
    chk("fair_rvalid", rvalid_o, 2'b00);
    chk("fair_cnt", grant_cnt_o, cnt_exp);

    // single read by requester 0
    cyc();
    req_i   = 2'b01;
    we_i    = 2'b00;
    addr_i  = {64'h0, 64'h4000};
    wdata_i = {64'h0, 64'h5555};
    #1;
    chk("rd_gnt", gnt_o, 2'b01);
    chk("rd_en", en_o, 1'b1);
    chk("rd_we", we_o, 1'b0);
    chk("rd_addr", address_o, 64'h4000);
    chk("rd_data_o", data_o, 64'h0);
    cyc(); req_i = 2'b00; data_i = 64'hDEAD_BEEF; #1;
    chk("rd_rvalid", rvalid_o, 2'b01);
    chk("rd_rdata", rdata_o, 64'hDEAD_BEEF);
    chk("rd_en_idle", en_o, 1'b0);

    // write by requester 1
    cyc();
    req_i   = 2'b10;
    we_i    = 2'b10;
    addr_i  = {64'h4008, 64'h0};
    wdata_i = {64'h1234, 64'h0};
    #1;
    chk("wr_gnt", gnt_o, 2'b10);
    chk("wr_en", en_o, 1'b1);
    chk("wr_we", we_o, 1'b1);
    chk("wr_addr", address_o, 64'h4008);
    chk("wr_data", data_o, 64'h1234);
    cyc(); req_i = 2'b00; we_i = 2'b00; #1;
    chk("wr_no_rvalid", rvalid_o, 2'b00);
    chk("wr_idle_data", data_o, 64'h0);

    // pipelined reads 0 then 1
    cyc(); req_i = 2'b01; addr_i = {64'h200, 64'h100}; #1;
    chk("pp_gnt0", gnt_o, 2'b01);
    chk("pp_addr0", address_o, 64'h100);
    cyc(); req_i = 2'b10; data_i = 64'hAAAA; #1;
    chk("pp_gnt1", gnt_o, 2'b10);
    chk("pp_addr1", address_o, 64'h200);
    chk("pp_rvalid0", rvalid_o, 2'b01);
    chk("pp_rdata0", rdata_o, 64'hAAAA);
    cyc(); req_i = 2'b00; data_i = 64'hBBBB; #1;
    chk("pp_rvalid1", rvalid_o, 2'b10);
    chk("pp_rdata1", rdata_o, 64'hBBBB);

    // back-to-back reads by the sole requester, wrap of scan
    cyc(); req_i = 2'b01; #1;
    chk("b2b_gnt_a", gnt_o, 2'b01);
    cyc(); data_i = 64'hC1; #1;
    chk("b2b_gnt_b", gnt_o, 2'b01);
    chk("b2b_rvalid_a", rvalid_o, 2'b01);
    cyc(); req_i = 2'b00; data_i = 64'hC2; #1;
    chk("b2b_rvalid_b", rvalid_o, 2'b01);
    chk("b2b_rdata_b", rdata_o, 64'hC2);

    // reset while a read is outstanding (pointer left at 1)
    cyc(); req_i = 2'b01; #1;
    chk("mr_gnt", gnt_o, 2'b01);
    cyc(); req_i = 2'b00; rst_i = 1'b1; #1;
    chk("mr_rvalid_rst", rvalid_o, 2'b00);
    cyc(); rst_i = 1'b0; #1;
    chk("mr_rvalid_after", rvalid_o, 2'b00);
    chk("mr_cnt", grant_cnt_o, 64'h0);
    cyc(); req_i = 2'b11; we_i = 2'b11; #1;
    chk("mr_ptr_gnt", gnt_o, 2'b01);
    cyc(); req_i = 2'b00; #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
